// File: rtl/ram_latency_responder.sv
// ============================================================================
// Module      : ram_latency_responder
// Description : Word-addressed RAM responder with fixed BUSY latency, answering
//               ren/wen requests with a FREE/BUSY/ACCESS/ERROR ramstate.
//               Optional build macro RAM_ERROR_CHECK_EN enables ERROR responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_latency_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [13:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [1:0]  ramstate
);

  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_next;
  logic                 r_ren;
  logic                 r_wen;
  logic [13:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_mem [DEPTH];

  logic                 w_req;
  logic                 w_legal;
  logic                 w_latch;
  logic                 w_access;
  logic                 w_from_inputs;
  logic                 w_acc_write;
  logic [c_idx_w-1:0]   w_acc_idx;
  logic [31:0]          w_acc_wdata;

  assign w_req = ren | wen;

`ifdef RAM_ERROR_CHECK_EN
  assign w_legal = !(ren && wen) && ({18'd0, addr} < 32'(DEPTH));
`else
  assign w_legal = 1'b1;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    w_access   = 1'b0;
    case (r_state)
      FREE: begin
        if (w_req) begin
          if (w_legal) begin
            w_latch = 1'b1;
            if (LAT == 0) begin
              w_next   = ACCESS;
              w_access = 1'b1;
            end else begin
              w_next     = BUSY;
              w_cnt_next = c_cnt_w'(LAT - 1);
            end
          end else begin
            w_next = ERROR;
          end
        end
      end
      BUSY: begin
        // Any change of the held request (other than wdata) abandons it.
        if ({ren, wen, addr} != {r_ren, r_wen, r_addr}) begin
          w_next = FREE;
        end else if (r_cnt == '0) begin
          w_next   = ACCESS;
          w_access = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ACCESS:  w_next = FREE;
      ERROR:   w_next = FREE;
      default: w_next = FREE;
    endcase
  end

  // Zero-latency accesses complete on the sampling edge, so use live inputs.
  assign w_from_inputs = (r_state == FREE);
  assign w_acc_write   = w_from_inputs ? wen : r_wen;
  assign w_acc_idx     = w_from_inputs ? addr[c_idx_w-1:0] : r_addr[c_idx_w-1:0];
  assign w_acc_wdata   = w_from_inputs ? wdata : r_wdata;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= FREE;
      r_cnt   <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      rdata   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_ren   <= ren;
        r_wen   <= wen;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (w_access && !w_acc_write) begin
        rdata <= r_mem[w_acc_idx];
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge CLK) begin
    if (nRST && w_access && w_acc_write) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  assign ramstate = r_state;

endmodule

`default_nettype wire
